// File: rtl/clk_divider_prog.sv
// Programmable 50%-duty clock divider with single-cycle rise/fall strobes.
// A ready/valid divisor update takes effect at a half-period boundary, or at once while disabled.
module clk_divider_prog #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 32'd250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] div_active,
  output logic             clkout,
  output logic             rise_tick,
  output logic             fall_tick
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO  = WIDTH'(0);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] div_pending_r;
  logic             pending_r;

  logic             bnd_s;
  logic             accept_s;
  logic             apply_s;

  // Decode the half-period boundary, handshake acceptance and divisor application
  always_comb begin
    bnd_s    = en && !clr && (count_r == div_active);
    accept_s = load_valid && !pending_r;
    // Applying only when the counter also restarts keeps count <= div_active
    apply_s  = pending_r && (!en || bnd_s);
  end

  assign load_ready = ~pending_r;

  // Counter, divided clock, strobes and divisor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r       <= CNT_ZERO;
      clkout        <= 1'b0;
      rise_tick     <= 1'b0;
      fall_tick     <= 1'b0;
      div_active    <= RESET_DIV;
      div_pending_r <= CNT_ZERO;
      pending_r     <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;

      if (clr) begin
        count_r <= CNT_ZERO;
        clkout  <= 1'b0;
      end else if (!en) begin
        if (pending_r) begin
          count_r <= CNT_ZERO;
        end else begin
          count_r <= count_r;
        end
      end else if (bnd_s) begin
        count_r   <= CNT_ZERO;
        clkout    <= ~clkout;
        rise_tick <= ~clkout;
        fall_tick <= clkout;
      end else begin
        count_r <= count_r + CNT_ONE;
      end

      if (apply_s) begin
        div_active <= div_pending_r;
        pending_r  <= 1'b0;
      end else if (accept_s) begin
        div_pending_r <= div_in;
        pending_r     <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed vector table, hand sequences
// for freeze/clear/reset/large divisor, and random traffic against a period-level model.
module tb_clk_divider_prog;

  localparam int W    = 8;
  localparam int DDIV = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         load_ready;
  logic [W-1:0] div_active;
  logic         clkout;
  logic         rise_tick;
  logic         fall_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .div_in    (div_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .div_active(div_active),
    .clkout    (clkout),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Reference model: tracks cycles spent in the current half-period and a pending-divisor queue
  int m_act;
  int m_elapsed;
  bit m_clk, m_rise, m_fall;
  int pend_q[$];

  task automatic model_reset();
    m_act = DDIV; m_elapsed = 0; m_clk = 0; m_rise = 0; m_fall = 0;
    pend_q.delete();
  endtask

  task automatic model_edge(input bit e, input bit c, input bit lv, input int d);
    bit acc;
    acc = lv && (pend_q.size() == 0);
    m_rise = 0; m_fall = 0;
    if (!e && pend_q.size() != 0) begin
      m_act = pend_q.pop_front();
      m_elapsed = 0;
    end
    if (c) begin
      m_elapsed = 0; m_clk = 0;
    end else if (e) begin
      if (m_elapsed + 1 == m_act + 1) begin
        m_clk = !m_clk;
        m_rise = m_clk; m_fall = !m_clk;
        m_elapsed = 0;
        if (pend_q.size() != 0) m_act = pend_q.pop_front();
      end else begin
        m_elapsed++;
      end
    end
    if (acc) pend_q.push_back(d);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("clkout", int'(clkout), int'(m_clk));
    check("rise_tick", int'(rise_tick), int'(m_rise));
    check("fall_tick", int'(fall_tick), int'(m_fall));
    check("load_ready", int'(load_ready), (pend_q.size() == 0) ? 1 : 0);
    check("div_active", int'(div_active), m_act);
  endtask

  task automatic step(input bit e, input bit c, input bit lv, input int d);
    logic [31:0] dv;
    dv = d;
    en = e; clr = c; load_valid = lv; div_in = dv[W-1:0];
    @(posedge clk);
    model_edge(e, c, lv, int'(dv[W-1:0]));
    #1;
    check_model();
  endtask

  typedef struct {
    bit en, clr, lv; int din;
    bit e_clk, e_rise, e_fall, e_rdy; int e_div;
  } vec_t;
  vec_t tbl[19];

  initial begin
    bit hold_clk;
    int n;

    tbl[0]  = '{1,0,0,0, 0,0,0,1,3};
    tbl[1]  = '{1,0,0,0, 0,0,0,1,3};
    tbl[2]  = '{1,0,0,0, 0,0,0,1,3};
    tbl[3]  = '{1,0,0,0, 1,1,0,1,3};
    tbl[4]  = '{1,0,1,1, 1,0,0,0,3};
    tbl[5]  = '{1,0,0,0, 1,0,0,0,3};
    tbl[6]  = '{1,0,0,0, 1,0,0,0,3};
    tbl[7]  = '{1,0,0,0, 0,0,1,1,1};
    tbl[8]  = '{1,0,0,0, 0,0,0,1,1};
    tbl[9]  = '{1,0,0,0, 1,1,0,1,1};
    tbl[10] = '{1,0,0,0, 1,0,0,1,1};
    tbl[11] = '{1,0,1,0, 0,0,1,0,1};
    tbl[12] = '{1,0,1,7, 0,0,0,0,1};
    tbl[13] = '{1,0,0,0, 1,1,0,1,0};
    tbl[14] = '{1,0,0,0, 0,0,1,1,0};
    tbl[15] = '{1,0,0,0, 1,1,0,1,0};
    tbl[16] = '{1,0,1,7, 0,0,1,0,0};
    tbl[17] = '{1,0,0,0, 1,1,0,1,7};
    tbl[18] = '{1,0,0,0, 1,0,0,1,7};

    // Reset state
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_model();
    @(posedge clk); #1;
    check("reset_hold_clkout", int'(clkout), 0);
    rst_n = 1'b1;

    // Directed table from a fresh reset
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].lv, tbl[i].din);
      check($sformatf("tbl%0d_clkout", i), int'(clkout), int'(tbl[i].e_clk));
      check($sformatf("tbl%0d_rise", i), int'(rise_tick), int'(tbl[i].e_rise));
      check($sformatf("tbl%0d_fall", i), int'(fall_tick), int'(tbl[i].e_fall));
      check($sformatf("tbl%0d_ready", i), int'(load_ready), int'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_div", i), int'(div_active), tbl[i].e_div);
    end

    // Freeze with en=0, then load while disabled
    step(1, 0, 0, 0);
    hold_clk = clkout;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      check("freeze_clkout", int'(clkout), int'(hold_clk));
      check("freeze_ticks", int'(rise_tick | fall_tick), 0);
    end
    step(0, 0, 1, 5);
    check("en0_accept_ready", int'(load_ready), 0);
    step(0, 0, 0, 0);
    check("en0_apply_div", int'(div_active), 5);
    check("en0_apply_ready", int'(load_ready), 1);
    n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
    end while (!(rise_tick | fall_tick) && n < 50);
    check("en0_first_toggle_cycles", n, 6);

    // Clear while clkout is high
    n = 0;
    while (clkout != 1'b1 && n < 50) begin
      step(1, 0, 0, 0);
      n++;
    end
    check("clr_pre_clkout", int'(clkout), 1);
    step(1, 1, 0, 0);
    check("clr_clkout", int'(clkout), 0);
    check("clr_no_fall", int'(fall_tick), 0);

    // Reset while an update is pending
    step(1, 0, 1, 2);
    check("pend_ready_low", int'(load_ready), 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_model();
    check("rst_pend_ready", int'(load_ready), 1);
    check("rst_pend_div", int'(div_active), DDIV);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

    // Largest divisor: half-period of 256 cycles
    step(1, 0, 1, 255);
    n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
    end while (!(rise_tick | fall_tick) && n < 600);
    check("max_div_apply_seen", int'(rise_tick | fall_tick), 1);
    n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
    end while (!(rise_tick | fall_tick) && n < 600);
    check("max_div_half_period", n, 256);
    check("max_div_active", int'(div_active), 255);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit e, c, lv;
      int d;
      e  = ($urandom % 8) != 0;
      c  = ($urandom % 40) == 0;
      lv = ($urandom % 4) == 0;
      d  = (($urandom % 32) == 0) ? 255 : int'($urandom % 7);
      step(e, c, lv, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Runtime-programmable clock divider / tick generator. Successor to the fixed-ratio divider used for slow display and step clocks. Adds a parametrised width, a reset value, enable and synchronous clear, and a divisor-update handshake that takes effect glitch-free at a half-period boundary. It also produces single-cycle rise/fall strobes for logic that stays in the `clk` domain.

Parameters:
WIDTH, 32, width of counter and divisor
DEFAULT_DIV, 250000, divisor loaded at reset; half-period = DEFAULT_DIV+1 clk cycles

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; 0 freezes counter and clkout
clr  input  1  synchronous clear of counter and clkout; priority over en
div_in  input  WIDTH  requested divisor
load_valid  input  1  div_in valid this cycle
load_ready  output  1  block can accept a divisor (no update pending)
div_active  output  WIDTH  divisor currently in use
clkout  output  1  divided clock, registered
rise_tick  output  1  one-cycle strobe, high in the cycle clkout is 1 after a 0→1 toggle
fall_tick  output  1  one-cycle strobe, high in the cycle clkout is 0 after a 1→0 toggle

Behaviour:
- Reset (rst_n=0, async):
  - count=0, clkout=0, rise_tick=0, fall_tick=0.
  - div_active=DEFAULT_DIV, pending=0, load_ready=1.
- Half-period boundary ("bnd"): en=1, clr=0, count==div_active.
  - Effects at the next posedge: clkout<=~clkout, count<=0, matching tick asserted for exactly that one cycle.
  - Full period = 2*(div_active+1) cycles.
- Counting: en=1, clr=0, no bnd → count<=count+1. Ticks are 0 in every non-bnd cycle.
- en=0, clr=0 → count, clkout hold; ticks 0.
- clr=1 (any en) → count<=0, clkout<=0, ticks 0. Pending divisor is kept; it applies at the next bnd, or per the en=0 rule below.
- Handshake:
  - load_ready = ~pending.
  - Accept when load_valid && load_ready: div_pending<=div_in, pending<=1.
  - load_valid with load_ready=0 is ignored; the source holds until ready.
- Apply rule:
  - At a bnd with pending=1: div_active<=div_pending, pending<=0.
  - The new value governs the half-period starting at count=0.
  - If en=0 and pending=1: apply on the next posedge and force count<=0; clkout holds.
- Simultaneous accept and bnd in the same cycle (pending was 0): bnd keeps the old div_active. The new value goes to pending and applies at the following bnd.
- An update can never leave count > div_active, because apply coincides with count<=0.
- Divisor edge cases:
  - div_active=0 → clkout toggles every enabled cycle (clk/2); ticks alternate every cycle.
  - div_active=2^WIDTH-1 is legal; no count overflow, since count wraps only via bnd.
- Duty cycle is always 50%; there is no odd-ratio mode.
- Reset mid-period or mid-handshake: everything returns to reset values, the pending divisor is discarded, and load_ready=1 in the first cycle after release.
- Outputs are fully registered; no combinational path from inputs to clkout or ticks. load_ready depends only on the pending register.

Test Plan:
- Reset then release, DEFAULT_DIV=3, en=1 → clkout first rises 4 cycles after release, then period 8 cycles, 50% duty; rise_tick/fall_tick each 1 cycle wide, aligned with clkout edges.
- Load div_in=1 mid high-phase (DEFAULT_DIV=3) → load_ready drops next cycle; the current half-period still lasts 4 cycles; subsequent half-periods last 2 cycles; load_ready returns to 1 at the applying bnd.
- load_valid asserted in the same cycle as a bnd, div_in=0 → that bnd uses the old divisor 3; the following half-period is 4 cycles; clk/2 toggling starts after it.
- Second load_valid (div_in=7) while pending → ignored; after apply, div_active equals the first value. Then re-present 7 → accepted.
- en=0 for 10 cycles at count=2 → clkout, count frozen, no ticks. Load div_in=5 while en=0 → div_active=5 next cycle, count=0. On en=1 → first toggle after 6 cycles.
- clr pulse with clkout=1 → clkout=0, count=0 next cycle, no fall_tick. rst_n low mid-pending → div_active=DEFAULT_DIV, load_ready=1.
